// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and helpers for the BCD keypad entry controller
package bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_WAIT_REL
  } key_state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_ZERO = 4'h0;

  function automatic logic onehot_valid(input logic [9:0] v);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < 10; i++) begin
      ones += int'(v[i]);
    end
    return (ones == 1);
  endfunction

endpackage

// File: rtl/onehot_to_bcd.sv
// rtl/onehot_to_bcd.sv - 9-bit one-hot to BCD encoder, bit k gives k+1, no bit gives 0
module onehot_to_bcd
  import bcd_pkg::*;
(
  input  logic [8:0]  onehot,
  output bcd_digit_t  bcd
);

  always_comb begin
    bcd = BCD_ZERO;
    for (int k = 0; k < 9; k++) begin
      if (onehot[k]) begin
        bcd = 4'(k + 1);
      end
    end
  end

endmodule

// File: rtl/bcd_key_entry_ctrl.sv
// rtl/bcd_key_entry_ctrl.sv - debounced 10-key pad feeding a packed BCD entry buffer
// with a valid/ready presentation to downstream logic.
module bcd_key_entry_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int DB_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [9:0]                   keys,
  input  logic                         enter,
  input  logic                         clear,
  output logic [4*DIGITS-1:0]          entry_bcd,
  output logic [$clog2(DIGITS+1)-1:0]  entry_count,
  output logic                         entry_valid,
  input  logic                         entry_ready,
  output logic                         key_err,
  output logic                         busy
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam int CW    = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CW-1:0]    COUNT_FULL = CW'(DIGITS);

  logic [9:0]           ks_meta_q, ks_q;
  key_state_e           state_q, state_d;
  logic [9:0]           snap_q, snap_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [4*DIGITS-1:0]  buf_q, buf_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 valid_q, valid_d;
  logic                 key_err_q, key_err_d;
  logic                 press_eval, push;
  bcd_digit_t           enc_bcd, digit;

  onehot_to_bcd u_enc (
    .onehot (snap_q[9:1]),
    .bcd    (enc_bcd)
  );

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    cnt_d      = cnt_q;
    press_eval = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ks_q != '0) begin
          snap_d  = ks_q;
          cnt_d   = '0;
          state_d = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (ks_q == '0) begin
          state_d = S_IDLE;
        end else if (ks_q != snap_q) begin
          snap_d = ks_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
          press_eval = 1'b1;
          cnt_d      = '0;
          state_d    = S_WAIT_REL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_REL: begin
        // Any bounce back to pressed restarts the release window, so holds never repeat.
        if (ks_q != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign push      = press_eval && onehot_valid(snap_q) && !valid_q;
  assign key_err_d = press_eval && !push;
  assign digit     = snap_q[0] ? BCD_ZERO : enc_bcd;

  always_comb begin
    buf_d   = buf_q;
    count_d = count_q;
    valid_d = valid_q;
    if (clear) begin
      buf_d   = '0;
      count_d = '0;
      valid_d = 1'b0;
    end else if (valid_q) begin
      if (entry_ready) begin
        buf_d   = '0;
        count_d = '0;
        valid_d = 1'b0;
      end
    end else begin
      if (push) begin
        buf_d      = buf_q << 4;
        buf_d[3:0] = digit;
        count_d    = count_q + 1'b1;
      end
      // Commit sees the post-push count so enter alongside a push includes that digit.
      if ((count_d == COUNT_FULL) || (enter && (count_d != '0))) begin
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks_meta_q <= '0;
      ks_q      <= '0;
      state_q   <= S_IDLE;
      snap_q    <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      key_err_q <= 1'b0;
    end else begin
      ks_meta_q <= keys;
      ks_q      <= ks_meta_q;
      state_q   <= state_d;
      snap_q    <= snap_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      key_err_q <= key_err_d;
    end
  end

  assign entry_bcd   = buf_q;
  assign entry_count = count_q;
  assign entry_valid = valid_q;
  assign key_err     = key_err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_bcd_key_entry_ctrl.sv
// tb/tb_bcd_key_entry_ctrl.sv - directed bench for bcd_key_entry_ctrl (DIGITS=4, DB_CYCLES=4)
module tb_bcd_key_entry_ctrl;

  logic        clk;
  logic        rst_n;
  logic [9:0]  keys;
  logic        enter;
  logic        clear;
  logic [15:0] entry_bcd;
  logic [2:0]  entry_count;
  logic        entry_valid;
  logic        entry_ready;
  logic        key_err;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int err_pulses = 0;
  int base;

  bcd_key_entry_ctrl #(
    .DIGITS    (4),
    .DB_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .keys        (keys),
    .enter       (enter),
    .clear       (clear),
    .entry_bcd   (entry_bcd),
    .entry_count (entry_count),
    .entry_valid (entry_valid),
    .entry_ready (entry_ready),
    .key_err     (key_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && key_err) err_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int k, input int hold, input int rel);
    keys = 10'(1 << k);
    step(hold);
    keys = '0;
    step(rel);
  endtask

  task automatic pulse_enter();
    enter = 1'b1;
    step(1);
    enter = 1'b0;
  endtask

  task automatic handshake();
    entry_ready = 1'b1;
    step(1);
    entry_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    keys = '0;
    enter = 1'b0;
    clear = 1'b0;
    entry_ready = 1'b0;
    step(3);
    check("rst_bcd", 32'(entry_bcd), 32'h0);
    check("rst_count", 32'(entry_count), 32'h0);
    check("rst_valid", 32'(entry_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(key_err), 32'h0);
    rst_n = 1'b1;
    step(2);

    // 1: four digits fill the buffer
    press(1, 12, 12);
    press(2, 12, 12);
    press(3, 12, 12);
    press(4, 12, 12);
    check("t1_valid", 32'(entry_valid), 32'h1);
    check("t1_bcd", 32'(entry_bcd), 32'h1234);
    check("t1_count", 32'(entry_count), 32'h4);
    step(10);
    check("t1_hold_bcd", 32'(entry_bcd), 32'h1234);
    check("t1_hold_valid", 32'(entry_valid), 32'h1);
    handshake();
    check("t1_drain_valid", 32'(entry_valid), 32'h0);
    check("t1_drain_bcd", 32'(entry_bcd), 32'h0);
    check("t1_drain_count", 32'(entry_count), 32'h0);

    // 2: bouncing key 5 then stable
    base = err_pulses;
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 10'b0000100000 : 10'b0;
      step(2);
    end
    keys = 10'b0000100000;
    step(12);
    keys = '0;
    step(12);
    check("t2_count", 32'(entry_count), 32'h1);
    check("t2_bcd", 32'(entry_bcd), 32'h0005);
    check("t2_no_err", 32'(err_pulses - base), 32'h0);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("t2_clear_count", 32'(entry_count), 32'h0);

    // 3: two keys at once
    base = err_pulses;
    keys = 10'b0010000100;
    step(12);
    keys = '0;
    step(12);
    check("t3_err", 32'(err_pulses - base), 32'h1);
    check("t3_count", 32'(entry_count), 32'h0);

    // 4: partial entry committed with enter, press while valid rejected
    press(9, 12, 12);
    press(0, 12, 12);
    pulse_enter();
    step(1);
    check("t4_valid", 32'(entry_valid), 32'h1);
    check("t4_bcd", 32'(entry_bcd), 32'h0090);
    check("t4_count", 32'(entry_count), 32'h2);
    base = err_pulses;
    press(6, 12, 12);
    check("t4_busy_err", 32'(err_pulses - base), 32'h1);
    check("t4_bcd_frozen", 32'(entry_bcd), 32'h0090);
    check("t4_count_frozen", 32'(entry_count), 32'h2);
    handshake();
    check("t4_drain_valid", 32'(entry_valid), 32'h0);

    // 5: enter on empty buffer; clear coinciding with a push
    pulse_enter();
    step(2);
    check("t5_empty_enter", 32'(entry_valid), 32'h0);
    base = err_pulses;
    keys = 10'b0100000000;
    step(5);
    check("t5_pre_push", 32'(entry_count), 32'h0);
    step(1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("t5_clr_count", 32'(entry_count), 32'h0);
    check("t5_clr_bcd", 32'(entry_bcd), 32'h0);
    keys = '0;
    step(12);
    check("t5_no_err", 32'(err_pulses - base), 32'h0);
    check("t5_still_empty", 32'(entry_count), 32'h0);

    // 6: async reset mid-debounce and mid-presentation
    keys = 10'b0000010000;
    step(4);
    check("t6_busy_pre", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_count", 32'(entry_count), 32'h0);
    keys = '0;
    step(2);
    rst_n = 1'b1;
    step(2);
    press(1, 12, 12);
    pulse_enter();
    step(1);
    check("t6_valid_pre", 32'(entry_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(entry_valid), 32'h0);
    check("t6_rst_bcd", 32'(entry_bcd), 32'h0);
    check("t6_rst_err", 32'(key_err), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(2);
    press(3, 12, 12);
    check("t6_fresh_count", 32'(entry_count), 32'h1);
    check("t6_fresh_digit", 32'(entry_bcd[3:0]), 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_key_entry_ctrl.md
Name: bcd_key_entry_ctrl

Overview:
Keypad entry controller for a 10-key decimal pad. It synchronises and debounces the raw key lines and rejects multi-key presses. Each clean press is encoded to one BCD digit through the team's one-hot-to-BCD encoder, and up to DIGITS digits accumulate into a packed BCD word. The word goes downstream (display/compare logic) on a valid/ready handshake, either when the buffer fills or when enter is pressed.

Parameters:
DIGITS, 4, number of BCD digits held per entry (1..8)
DB_CYCLES, 16, consecutive stable cycles required to accept a press or a release (>=2)
CNT_W, $clog2(DB_CYCLES), debounce counter width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
keys  in  10  raw key lines, bit i = digit i pressed; asynchronous to clk
enter  in  1  synchronous pulse: commit a partial entry
clear  in  1  synchronous pulse: discard buffer and any pending entry
entry_bcd  out  4*DIGITS  packed BCD; newest digit in [3:0]
entry_count  out  $clog2(DIGITS+1)  digits in entry_bcd
entry_valid  out  1  entry_bcd/entry_count valid and stable
entry_ready  in  1  downstream accepts when entry_valid && entry_ready
key_err  out  1  one-cycle pulse: press rejected
busy  out  1  key FSM not in S_IDLE

Behaviour:
- Reset (rst_n low, asynchronous): FSM to S_IDLE; synchroniser, counter, snapshot, buffer cleared; every output 0.
- Input path: keys pass through a 2-flop synchroniser (ks). The FSM sees only ks.
- Key FSM states: S_IDLE, S_DEBOUNCE, S_WAIT_REL.
- S_IDLE: if ks != 0, store snap = ks, set cnt = 0, and go to S_DEBOUNCE.
- S_DEBOUNCE:
  - If ks == 0, go to S_IDLE.
  - Else if ks != snap, set snap = ks and cnt = 0; stay.
  - Else if cnt == DB_CYCLES-1, evaluate the press and go to S_WAIT_REL with cnt = 0.
  - Else cnt++.
- Press evaluation:
  - snap is one-hot and entry_valid == 0: push the digit. Bit 0 gives 4'h0. Bits [9:1] drive the encoder (9-bit one-hot, bit k gives BCD k+1).
  - snap has more than one bit set, or entry_valid == 1: drop the press and pulse key_err for one cycle.
- S_WAIT_REL: any ks != 0 resets cnt. After DB_CYCLES consecutive cycles of ks == 0, go to S_IDLE. Holding a key never repeats it.
- Push: entry_bcd <= {entry_bcd[4*DIGITS-5:0], digit}; entry_count++. If entry_count reaches DIGITS, set entry_valid = 1 on the next cycle.
- enter:
  - With entry_count > 0 and entry_valid == 0, set entry_valid = 1 on the next cycle.
  - With entry_count == 0 it is ignored.
  - Same cycle as a push: the push happens first, then the commit includes the new digit.
- Handshake:
  - While entry_valid == 1, entry_bcd and entry_count stay frozen.
  - On entry_valid && entry_ready, the next cycle has entry_valid = 0, entry_bcd = 0 and entry_count = 0.
  - entry_ready is ignored while entry_valid == 0.
- clear: next cycle has buffer = 0, entry_count = 0 and entry_valid = 0. It does not affect the key FSM. If clear coincides with a push or a handshake, clear wins and the digit is lost (no key_err).
- Latency: a key held clean at the pins reaches the buffer 2 (sync) + 1 (S_IDLE exit) + DB_CYCLES cycles later.
- busy = (state != S_IDLE).

Decomposition:
- Package bcd_pkg:
  - key FSM state enum (S_IDLE, S_DEBOUNCE, S_WAIT_REL)
  - BCD digit typedef (logic [3:0])
  - constant BCD_ZERO = 4'h0
  - onehot_valid function (popcount == 1)
- Sub-module: onehot_to_bcd, the combinational 9-bit one-hot to 4-bit BCD encoder with default 0. It is instantiated once.
- The synchroniser stays inline.

Test Plan (DIGITS=4, DB_CYCLES=4):
1. Press keys 1, 2, 3, 4 in turn, each held 12 cycles with 12 cycles released, entry_ready=0 -> entry_valid=1, entry_bcd=16'h1234, entry_count=4. The values hold until entry_ready=1; the next cycle has valid=0 and bcd=0.
2. keys bit5 toggles every 2 cycles for 12 cycles, then stays stable for 12 cycles -> exactly one push of digit 5, key_err never asserted.
3. keys=10'b0010000100 (keys 2 and 7) for 12 cycles -> one key_err pulse, entry_count stays 0.
4. Press 9 then 0, then pulse enter -> entry_valid=1, entry_bcd=16'h0090, entry_count=2. A press of 6 while valid gives key_err and leaves the data unchanged.
5. Pulse enter with an empty buffer -> no valid. Push 8 with clear in the same cycle as the push -> buffer 0, count 0, no key_err.
6. Drop rst_n mid-S_DEBOUNCE and mid-presentation -> all outputs 0 immediately, busy=0. After release, a fresh press of 3 gives entry_count=1, entry_bcd[3:0]=3.
